// File: rtl/uart_pkg.sv
// Shared UART definitions: baud indices, divisor and frame-length helpers.
// Used by the bit timer and by the TX/RX shift logic.
package uart_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } timer_state_t;

    localparam logic [3:0] BAUD_300    = 4'd0;
    localparam logic [3:0] BAUD_1200   = 4'd1;
    localparam logic [3:0] BAUD_2400   = 4'd2;
    localparam logic [3:0] BAUD_4800   = 4'd3;
    localparam logic [3:0] BAUD_9600   = 4'd4;
    localparam logic [3:0] BAUD_19200  = 4'd5;
    localparam logic [3:0] BAUD_38400  = 4'd6;
    localparam logic [3:0] BAUD_57600  = 4'd7;
    localparam logic [3:0] BAUD_115200 = 4'd8;
    localparam logic [3:0] BAUD_230400 = 4'd9;
    localparam logic [3:0] BAUD_460800 = 4'd10;
    localparam logic [3:0] BAUD_921600 = 4'd11;

    // Indices 12..15 are reserved and fall back to 9600.
    function automatic int unsigned baud_rate(input logic [3:0] idx);
        int unsigned b;
        case (idx)
            BAUD_300:    b = 300;
            BAUD_1200:   b = 1200;
            BAUD_2400:   b = 2400;
            BAUD_4800:   b = 4800;
            BAUD_19200:  b = 19200;
            BAUD_38400:  b = 38400;
            BAUD_57600:  b = 57600;
            BAUD_115200: b = 115200;
            BAUD_230400: b = 230400;
            BAUD_460800: b = 460800;
            BAUD_921600: b = 921600;
            default:     b = 9600;
        endcase
        return b;
    endfunction

    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input logic [3:0]  idx);
        int unsigned b;
        b = baud_rate(idx);
        return (clk_hz + b / 2) / b;
    endfunction

    function automatic logic [3:0] frame_len(input logic [1:0] dbits,
                                             input logic       par,
                                             input logic       stop2);
        return 4'd7 + {2'b00, dbits} + {3'b000, par} + {3'b000, stop2};
    endfunction

endpackage

// File: rtl/uart_bit_timer_if.sv
// Control/status bundle between a UART shifter and its bit timer.
// The shifter drives config and start/abort; the timer returns strobes.
interface uart_bit_timer_if;
    logic       start;
    logic       abort;
    logic       half_first;
    logic [3:0] baud_val;
    logic [1:0] data_bits;
    logic       parity_en;
    logic       stop2;
    logic       btu;
    logic [3:0] bit_idx;
    logic       busy;
    logic       done;

    modport master (
        output start, abort, half_first, baud_val,
        output data_bits, parity_en, stop2,
        input  btu, bit_idx, busy, done
    );

    modport slave (
        input  start, abort, half_first, baud_val,
        input  data_bits, parity_en, stop2,
        output btu, bit_idx, busy, done
    );
endinterface

// File: rtl/baud_tick_gen.sv
// Divisor lookup and interval counter; emits registered BTU strobes.
// o_tick is the combinational "fires on this edge" used by the frame counter.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned DIV_W  = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  logic [3:0] i_baud,
    input  logic       i_half,
    output logic       o_tick,
    output logic       o_btu
);

    logic [DIV_W-1:0] w_tab [16];
    logic [DIV_W-1:0] w_div;
    logic [DIV_W-1:0] w_len;
    logic [DIV_W-1:0] r_cnt;
    logic             r_first;
    logic             r_btu;

    // Table entries are elaboration-time constants, so no divider is built.
    for (genvar g = 0; g < 16; g++) begin : g_tab
        assign w_tab[g] = DIV_W'(baud_div(CLK_HZ, 4'(g)));
    end

    assign w_div  = w_tab[i_baud];
    assign w_len  = (r_first && i_half) ? (w_div >> 1) : w_div;
    assign o_tick = i_en && (r_cnt == w_len - DIV_W'(1));
    assign o_btu  = r_btu;

    always_ff @(posedge clk) begin
        if (reset || !i_en) begin
            r_cnt   <= '0;
            r_first <= 1'b1;
            r_btu   <= 1'b0;
        end else if (o_tick) begin
            r_cnt   <= '0;
            r_first <= 1'b0;
            r_btu   <= 1'b1;
        end else begin
            r_cnt   <= r_cnt + DIV_W'(1);
            r_btu   <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_bit_timer.sv
// UART frame bit timer: config latch, IDLE/RUN FSM, bit counter, done/busy.
// Counts BTUs from baud_tick_gen across a frame of 7..12 bits.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned DIV_W  = 18
) (
    input  logic             clk,
    input  logic             reset,
    uart_bit_timer_if.slave  bus
);

    timer_state_t r_state;
    timer_state_t w_state_nxt;

    logic [3:0] r_baud;
    logic [1:0] r_dbits;
    logic       r_par;
    logic       r_stop2;
    logic       r_half;
    logic [3:0] r_bit_idx;
    logic       r_busy;
    logic       r_done;

    logic       w_start_ok;
    logic       w_tick_en;
    logic       w_tick;
    logic       w_btu;
    logic       w_last;
    logic [3:0] w_n;
    logic [3:0] w_idx_inc;

    assign w_n       = frame_len(r_dbits, r_par, r_stop2);
    assign w_idx_inc = r_bit_idx + 4'd1;
    assign w_last    = w_tick && (w_idx_inc == w_n);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // RUN is left one edge after the final BTU, while done is visible.
    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_tick_en   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort || r_done) w_state_nxt = ST_IDLE;
                else                     w_tick_en   = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud    <= '0;
            r_dbits   <= '0;
            r_par     <= 1'b0;
            r_stop2   <= 1'b0;
            r_half    <= 1'b0;
            r_bit_idx <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_ok) begin
                r_baud    <= bus.baud_val;
                r_dbits   <= bus.data_bits;
                r_par     <= bus.parity_en;
                r_stop2   <= bus.stop2;
                r_half    <= bus.half_first;
                r_bit_idx <= '0;
                r_busy    <= 1'b1;
            end else if (w_state_nxt == ST_IDLE) begin
                r_bit_idx <= '0;
                r_busy    <= 1'b0;
            end else if (w_tick) begin
                r_bit_idx <= w_idx_inc;
                r_done    <= w_last;
            end
        end
    end

    baud_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .DIV_W  (DIV_W)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_tick_en),
        .i_baud (r_baud),
        .i_half (r_half),
        .o_tick (w_tick),
        .o_btu  (w_btu)
    );

    assign bus.btu     = w_btu;
    assign bus.bit_idx = r_bit_idx;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule

// File: doc/uart_bit_timer.md
# uart_bit_timer

Parametrised bit-timing engine for the UART transmitter and receiver. It generates one-cycle bit-time-unit (BTU) strobes at a selectable baud rate and counts them across a configurable frame. It signals completion after the last stop bit. It replaces the fixed 11-BTU baud/bit counter pair, adding these features:
- data-width, parity and stop-bit configuration;
- a receive-mode half-bit first interval for mid-bit sampling;
- abort;
- a frame-position output.

## Interface
Parameters:
- CLK_HZ, 50_000_000: system clock frequency; used only to build the divisor table.
- DIV_W, 18: divisor/counter width. It must hold the largest divisor (300 baud).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a frame; honoured only when idle.
- abort  in  1  terminates the current frame immediately; no done.
- half_first  in  1  1 = first interval is half a bit (RX start-bit centring).
- baud_val  in  4  baud select.
- data_bits  in  2  00..11 = 5..8 data bits.
- parity_en  in  1  adds one parity bit to the frame.
- stop2  in  1  0 = one stop bit, 1 = two stop bits.
- btu  out  1  one-cycle strobe at each bit boundary.
- bit_idx  out  4  BTUs elapsed in the current frame.
- busy  out  1  frame in progress.
- done  out  1  one-cycle strobe coincident with the final BTU.

## Operation
- Baud table (baud_val → baud, divisor DIV = round(CLK_HZ/baud); values shown for 50 MHz):
  - 0: 300 (166667)
  - 1: 1200 (41667)
  - 2: 2400 (20833)
  - 3: 4800 (10417)
  - 4: 9600 (5208)
  - 5: 19200 (2604)
  - 6: 38400 (1302)
  - 7: 57600 (868)
  - 8: 115200 (434)
  - 9: 230400 (217)
  - 10: 460800 (109)
  - 11: 921600 (54)
  - 12–15: reserved; these map to 9600.
- Frame length N = 1 + (5 + data_bits) + parity_en + 1 + stop2. N ranges from 7 to 12.
- The edge that samples start while idle does the following:
  - latches baud_val, data_bits, parity_en, stop2 and half_first;
  - sets busy = 1, count = 0, bit_idx = 0.
  - Input changes after this edge have no effect until the next frame.
- Two states, IDLE and RUN:
  - IDLE→RUN on start (abort low).
  - RUN→IDLE on the final BTU, on abort, or on reset.
- Interval counter (RUN):
  - Increments each cycle.
  - When it reaches the current interval length it does all of the following on that edge: asserts btu for one cycle, clears the counter, and increments bit_idx.
- Interval length:
  - First interval is DIV>>1 if the latched half_first = 1, otherwise DIV.
  - All later intervals are DIV.
- When the BTU that makes bit_idx = N fires:
  - done is asserted in the same cycle;
  - on the next edge, busy = 0 and bit_idx = 0.
- Boundary rules:
  - start while busy: ignored.
  - start and abort in the same cycle while idle: abort wins, stays IDLE.
  - abort while busy: next edge gives busy = 0, bit_idx = 0, no btu, no done, even if the BTU would have fired that cycle.
  - reset mid-frame: same effect as abort.
  - Reserved baud_val: behaves exactly as 4.

## Timing
- Reset values: btu = 0, done = 0, busy = 0, bit_idx = 0, counter = 0, state = IDLE.
- All outputs are registered.
- busy rises in the cycle after start is sampled.
- Full-interval BTUs are high in the cycles following rising edges k·DIV (k = 1..N), counted from the start-sampling edge.
- With half_first = 1, the first BTU is at (DIV>>1) and later BTUs at (DIV>>1) + k·DIV.
- A new start is accepted no earlier than the cycle in which busy reads 0. Back-to-back frames therefore have a one-cycle gap.

## Structure
- Shared package uart_pkg holds:
  - the baud-index constants;
  - the divisor function computing round(CLK_HZ/baud);
  - the frame-length function.
- These are also used by the TX/RX shift logic.
- One sub-module, baud_tick_gen, contains the divisor lookup, the interval counter and the half-first logic, and emits btu.
- The top level holds the FSM, bit counter, config latch and done/busy.

## Test plan
- 8N1 at baud_val 11, half_first 0: start → 10 btu pulses 54 cycles apart, done with the 10th btu at cycle 540, busy low at 541.
- RX 8N1 at baud_val 11, half_first 1: first btu at 27, then every 54; done at 513.
- 5 data bits, parity, 2 stop bits (N = 9) at baud_val 11: done at 486, bit_idx steps 1..9. Inputs toggled mid-frame have no effect.
- baud_val 13 (reserved): btu spacing 5208 cycles, identical to baud_val 4.
- abort at cycle 200 of an 8N1 frame at baud_val 11: busy = 0 and bit_idx = 0 next cycle, no done. A start issued during the frame is ignored. Simultaneous start + abort in idle keeps busy = 0.
- reset asserted at cycle 300 mid-frame: all outputs return to reset values on the next edge. A subsequent start yields a normal frame.
